// File: rtl/uart_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_sipo_rx
// Description : Oversampling UART receiver. Handles 7/8 data bits,
//               none/odd/even parity and 1/2 stop bits. It validates the
//               start bit, then presents the word with parity and framing
//               status for one cycle on rx_done.
//               Optional build macro UART_RX_MAJORITY_VOTE_EN makes each
//               sample a 2-of-3 vote over the last three synchronized values.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sipo_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_out,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    // The edge-detect cycle counts as tick 0 of the start bit, and START is
    // entered one cycle later. Comparing against half-2 therefore places the
    // start sample at edge + OVERSAMPLE/2 - 1.
    localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [1:0]    sync_ff;
    logic          line_sync;
    logic          line_prev;
    logic          sample;
    logic [TW-1:0] tick;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_acc;
    logic          par_err_acc;
    logic          frame_acc;
    logic [1:0]    fmt_parity;
    logic          fmt_stop2;
    logic          fmt_len8;
    logic          edge_det;
    logic          start_hit;
    logic          bit_hit;
    logic          last_cnt;
    logic          par_en;

    // Two-flop synchronizer for the asynchronous pin plus the previous value for edge detection
    always_ff @(posedge baud_out) begin
        if (rst) begin
            sync_ff   <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_ff   <= {sync_ff[0], data_in};
            line_prev <= line_sync;
        end
    end

    assign line_sync = sync_ff[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [2:0] hist;

    // History of synchronized values used for 2-of-3 glitch rejection
    always_ff @(posedge baud_out) begin
        if (rst) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], line_sync};
        end
    end

    assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign sample = line_sync;
`endif

    assign edge_det  = line_prev & ~line_sync;
    assign start_hit = (state == S_START) && (tick == TICK_START);
    assign bit_hit   = (tick == TICK_LAST);
    assign last_cnt  = (bit_cnt == 4'd1);
    // Only 01 (odd) and 10 (even) carry a parity bit.
    assign par_en    = fmt_parity[0] ^ fmt_parity[1];

    // State register
    always_ff @(posedge baud_out) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (edge_det) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (start_hit) begin
                    state_next = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_hit && last_cnt) begin
                    state_next = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_hit) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_hit && last_cnt) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: activity flag and the one-cycle completion strobe
    always_comb begin
        rx_active = 1'b0;
        rx_done   = 1'b0;
        case (state)
            S_START:  rx_active = start_hit & ~sample;
            S_DATA:   rx_active = 1'b1;
            S_PARITY: rx_active = 1'b1;
            S_STOP:   rx_active = 1'b1;
            S_DONE: begin
                rx_active = 1'b1;
                rx_done   = 1'b1;
            end
            default: begin
                rx_active = 1'b0;
                rx_done   = 1'b0;
            end
        endcase
    end

    // Datapath: tick/bit counters, shift register, parity and framing accumulators, result registers
    always_ff @(posedge baud_out) begin
        if (rst) begin
            tick         <= '0;
            bit_cnt      <= 4'd0;
            shift_reg    <= 8'h00;
            par_acc      <= 1'b0;
            par_err_acc  <= 1'b0;
            frame_acc    <= 1'b0;
            fmt_parity   <= 2'b00;
            fmt_stop2    <= 1'b0;
            fmt_len8     <= 1'b0;
            data_out     <= 8'h00;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tick <= '0;
                    if (edge_det) begin
                        fmt_parity <= parity_type;
                        fmt_stop2  <= stop_bits;
                        fmt_len8   <= data_length;
                    end
                end
                S_START: begin
                    if (start_hit) begin
                        tick        <= '0;
                        bit_cnt     <= fmt_len8 ? 4'd8 : 4'd7;
                        par_acc     <= 1'b0;
                        par_err_acc <= 1'b0;
                        frame_acc   <= 1'b0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_hit) begin
                        tick      <= '0;
                        shift_reg <= {sample, shift_reg[7:1]};
                        par_acc   <= par_acc ^ sample;
                        // After the last data bit the counter is reused for the stop bits.
                        if (last_cnt) begin
                            bit_cnt <= fmt_stop2 ? 4'd2 : 4'd1;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_hit) begin
                        tick        <= '0;
                        // Odd mode needs total XOR 1, even needs 0; fmt_parity[0] is that target.
                        par_err_acc <= (par_acc ^ sample) != fmt_parity[0];
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_hit) begin
                        tick <= '0;
                        if (!sample) begin
                            frame_acc <= 1'b1;
                        end
                        // Results are loaded on entry to DONE so they are valid alongside rx_done.
                        if (last_cnt) begin
                            data_out     <= fmt_len8 ? shift_reg : {1'b0, shift_reg[7:1]};
                            parity_error <= par_en & par_err_acc;
                            frame_error  <= frame_acc | ~sample;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    tick <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_sipo_rx
// Description : Scoreboard bench for uart_sipo_rx. Directed frames push their
//               hand-computed result; a monitor pops and compares on rx_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sipo_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_out;
    logic       rx_active;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors        = 0;
    int   checks        = 0;
    int   cyc           = 0;
    int   done_cnt      = 0;
    int   last_done_cyc = 0;
    bit   active_seen   = 1'b0;

    always #5 clk = ~clk;

    uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
        .baud_out     (clk),
        .rst          (rst),
        .data_in      (data_in),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_out     (data_out),
        .rx_active    (rx_active),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_q.push_back('{d: d, pe: pe, fe: fe});
    endtask

    // Monitor: compares every rx_done against the oldest expected frame
    always @(negedge clk) begin
        if (rx_active === 1'b1) active_seen = 1'b1;
        if (rx_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got rx_done with data_out=%0h expected no rx_done", data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.d});
                check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
                check("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
            end
        end
    end

    task automatic idle(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_in = level;
        end
    endtask

    // Drives one frame; pbit is the parity bit (used only when parity enabled),
    // stop_val is driven on every stop bit, glitch is a cycle offset forced high (-1 none).
    task automatic drive_frame(input logic [7:0] d, input bit len8, input logic [1:0] ptype,
                               input bit stop2, input bit pbit, input bit stop_val,
                               input int glitch, output int start_c);
        logic [11:0] bits;
        int          n;
        bits = '0;
        n    = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < (len8 ? 8 : 7); i++) begin
            bits[n] = d[i];
            n++;
        end
        if (ptype == 2'b01 || ptype == 2'b10) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = stop_val;
        n++;
        if (stop2) begin
            bits[n] = stop_val;
            n++;
        end
        start_c = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < OS; k++) begin
                @(negedge clk);
                if (i == 0 && k == 0) begin
                    parity_type = ptype;
                    stop_bits   = stop2;
                    data_length = len8;
                    start_c     = cyc;
                end
                data_in = ((i * OS + k) == glitch) ? 1'b1 : bits[i];
            end
        end
    endtask

    initial begin
        int sc;
        int dummy;
        int n_before;
        int diff;

        rst         = 1'b1;
        data_in     = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_length = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out", {24'd0, data_out}, 32'h00);
        check("reset_rx_active", {31'd0, rx_active}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_parity_error", {31'd0, parity_error}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        idle(1'b1, 10);

        // 8N1 0xA5. Pin falls before posedge sc+1; sync output low after sc+2 (t0);
        // stop bit (n=9) sampled at t0+7+144, rx_done at t0+152 => monitor sees cyc sc+154.
        expect_frame(8'hA5, 1'b0, 1'b0);
        drive_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, -1, sc);
        idle(1'b1, 20);
        diff = last_done_cyc - sc;
        checks++;
        if (diff < 153 || diff > 155) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles expected 154 +/-1", diff);
        end

        // 7E2 0x41: two ones, even parity bit 0; then same frame with parity bit 1.
        expect_frame(8'h41, 1'b0, 1'b0);
        drive_frame(8'h41, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, -1, dummy);
        expect_frame(8'h41, 1'b1, 1'b0);
        drive_frame(8'h41, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, -1, dummy);
        idle(1'b1, 20);

        // 8O1 0x3C: four ones, odd parity bit 1; stop bit driven low, then line held low.
        expect_frame(8'h3C, 1'b0, 1'b1);
        drive_frame(8'h3C, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, -1, dummy);
        n_before = done_cnt;
        idle(1'b0, 80);
        check("no_retrigger_low", done_cnt, n_before);
        idle(1'b1, 40);

        // 4-cycle low pulse: a false start.
        active_seen = 1'b0;
        n_before    = done_cnt;
        idle(1'b0, 4);
        idle(1'b1, 40);
        check("false_start_active", {31'd0, active_seen}, 32'd0);
        check("false_start_done", done_cnt, n_before);

        // Back-to-back 8N1 0x00 and 0xFF, then a third frame aborted by reset in DATA.
        expect_frame(8'h00, 1'b0, 1'b0);
        drive_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, -1, dummy);
        expect_frame(8'hFF, 1'b0, 1'b0);
        drive_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, -1, dummy);
        idle(1'b0, 40);
        check("active_in_data", {31'd0, rx_active}, 32'd1);
        @(negedge clk);
        rst     = 1'b1;
        data_in = 1'b1;
        @(negedge clk);
        check("abort_data_out", {24'd0, data_out}, 32'h00);
        check("abort_rx_active", {31'd0, rx_active}, 32'd0);
        check("abort_rx_done", {31'd0, rx_done}, 32'd0);
        check("abort_parity_error", {31'd0, parity_error}, 32'd0);
        check("abort_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        idle(1'b1, 200);

        // 8N1 0x00 with a 1-cycle high glitch at the data bit 3 sample point (frame offset 4*16+7).
`ifdef UART_RX_MAJORITY_VOTE_EN
        expect_frame(8'h00, 1'b0, 1'b0);
`else
        expect_frame(8'h08, 1'b0, 1'b0);
`endif
        drive_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4 * OS + 7, dummy);
        idle(1'b1, 30);

        check("done_count", done_cnt, 7);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
